// File: rtl/adc_burst_streamer.sv
// Captures a burst of ADC samples into a local buffer, then drains it to the
// FT2232H FIFO write port as a framed byte stream: HDR, {hi,lo} per sample, TRL.
module adc_burst_streamer #(
  parameter int          ADC_BITS = 10,
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 1024,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter logic [7:0]  TRL_BYTE = 8'h5A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic [ADDR_W:0]     num_samples,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic                busy,
  output logic                done,
  output logic                wr_en,
  output logic [7:0]          wr_data,
  input  logic                wr_full
);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, HEADER, RD_PREFETCH, SEND_HI, SEND_LO, TRAILER, FINISH
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt, cnt_n;
  logic [ADDR_W:0]     len, len_n;
  logic                busy_n, done_n, wr_en_n;
  logic [7:0]          wr_data_n;
  logic                mem_we, mem_re;
  logic [ADC_BITS-1:0] mem [DEPTH];
  logic [ADC_BITS-1:0] rd_data;
  logic [15:0]         samp16;
  logic                last, can_issue;

  assign samp16    = 16'(rd_data);
  assign last      = ({1'b0, cnt} == (len - 1'b1));
  // Spacing writes by one idle cycle keeps wr_en from ever being high twice in a row.
  assign can_issue = !wr_full && !wr_en;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    len_n     = len;
    busy_n    = busy;
    done_n    = 1'b0;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: if (trig) begin
        len_n   = (num_samples == '0 || num_samples > DEPTH_L) ? DEPTH_L : num_samples;
        cnt_n   = '0;
        busy_n  = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: begin
        mem_we = 1'b1;
        if (last) begin
          cnt_n   = '0;
          state_n = HEADER;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HEADER: if (can_issue) begin
        wr_en_n   = 1'b1;
        wr_data_n = HDR_BYTE;
        state_n   = RD_PREFETCH;
      end
      RD_PREFETCH: begin
        mem_re  = 1'b1;
        state_n = SEND_HI;
      end
      SEND_HI: if (can_issue) begin
        wr_en_n   = 1'b1;
        wr_data_n = samp16[15:8];
        state_n   = SEND_LO;
      end
      SEND_LO: if (can_issue) begin
        wr_en_n   = 1'b1;
        wr_data_n = samp16[7:0];
        if (last) begin
          state_n = TRAILER;
        end else begin
          cnt_n   = cnt + 1'b1;
          state_n = RD_PREFETCH;
        end
      end
      TRAILER: if (can_issue) begin
        wr_en_n   = 1'b1;
        wr_data_n = TRL_BYTE;
        state_n   = FINISH;
      end
      FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len     <= len_n;
      busy    <= busy_n;
      done    <= done_n;
      wr_en   <= wr_en_n;
      wr_data <= wr_data_n;
    end
  end

  // Single-port buffer: the FSM never asserts write and read together.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt] <= adc_data;
    if (mem_re) rd_data  <= mem[cnt];
  end

endmodule

// File: tb/tb_adc_burst_streamer.sv
// Randomized self-checking bench: expected frames are built from the sample
// list driven into the ADC port and compared with bytes seen on the FIFO port.
module tb_adc_burst_streamer;
  localparam int AB  = 10;
  localparam int AW  = 10;
  localparam int DEP = 1024;

  typedef logic [AB-1:0] samp_q_t[$];

  logic          clk = 1'b0, rst = 1'b1, trig = 1'b0, wr_full = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic [AB-1:0] adc_data = '0;
  logic          busy, done, wr_en;
  logic [7:0]    wr_data;

  adc_burst_streamer #(.ADC_BITS(AB), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .trig(trig), .num_samples(num_samples),
    .adc_data(adc_data), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_data(wr_data), .wr_full(wr_full)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  int         cyc = 0, done_cnt = 0, last_wr_cyc = -1, done_cyc = -1;
  logic [7:0] got[$];
  logic       prev_wr_en = 1'b0, prev_wr_full = 1'b0;
  bit         bp_on = 1'b0;

  always @(posedge clk) cyc++;

  // Byte collector and FIFO protocol checker.
  always @(negedge clk) begin
    if (wr_en) begin
      got.push_back(wr_data);
      last_wr_cyc = cyc;
      checks++;
      if (prev_wr_en || prev_wr_full) begin
        errors++;
        $display("FAIL protocol: wr_en high with prev_wr_en=%0b prev_wr_full=%0b, required both 0",
                 prev_wr_en, prev_wr_full);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_wr_en   = wr_en;
    prev_wr_full = wr_full;
  end

  // Random FIFO backpressure, each level held 1..20 cycles.
  initial begin
    int hold = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_on) begin
        if (hold == 0) begin
          wr_full = 1'($urandom_range(0, 1));
          hold    = $urandom_range(1, 20);
        end
        hold--;
      end else begin
        wr_full = 1'b0;
        hold    = 0;
      end
    end
  end

  // Pulse trig and feed one sample per cycle starting the cycle after trig.
  task automatic start_burst(input int n, input samp_q_t s, input bit extra);
    @(posedge clk); #1;
    trig        = 1'b1;
    num_samples = (AW+1)'(n);
    @(posedge clk); #1;
    for (int i = 0; i < s.size(); i++) begin
      adc_data = s[i];
      if (extra && i == 1) begin
        trig        = 1'b1;
        num_samples = (AW+1)'(2);
      end else begin
        trig = 1'b0;
      end
      @(posedge clk); #1;
    end
    trig     = 1'b0;
    adc_data = AB'($urandom);
  endtask

  task automatic run_burst(input string name, input int n, input samp_q_t s, input bit extra);
    logic [7:0]  exp[$];
    logic [15:0] v;
    int d0, t, mism, first;
    exp.push_back(8'hA5);
    foreach (s[i]) begin
      v = 16'(s[i]);
      exp.push_back(v[15:8]);
      exp.push_back(v[7:0]);
    end
    exp.push_back(8'h5A);
    got.delete();
    d0 = done_cnt;
    start_burst(n, s, extra);
    if (extra) begin
      t = 0;
      while (got.size() < 3 && t < 2000) begin @(posedge clk); t++; end
      #1 trig = 1'b1;
      num_samples = (AW+1)'(1);
      @(posedge clk); #1 trig = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 40 * exp.size() + 200) begin @(posedge clk); t++; end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s done_timeout: no done after %0d cycles, required done pulse", name, t);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: got %0b required 0", name, busy);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s frame_len: got %0d bytes required %0d", name, got.size(), exp.size());
    end
    mism = 0;
    first = -1;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s frame_bytes: %0d wrong, first at %0d got %02h required %02h",
               name, mism, first, got[first], exp[first]);
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_count: got %0d pulses busy=%0b, required 1 pulse busy=0",
               name, done_cnt - d0, busy);
    end
  endtask

  function automatic samp_q_t rand_samples(input int len);
    samp_q_t q;
    for (int i = 0; i < len; i++) q.push_back(AB'($urandom));
    return q;
  endfunction

  function automatic samp_q_t ramp(input int start, input int len);
    samp_q_t q;
    for (int i = 0; i < len; i++) q.push_back(AB'(start + i));
    return q;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, wr_en, wr_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b wr_en=%0b wr_data=%02h required all 0",
               busy, done, wr_en, wr_data);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    run_burst("basic", 4, ramp(10'h3FC, 4), 1'b0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      bp_on = 1'b1;
      run_burst("backpressure", 3, rand_samples(3), 1'b0);
      bp_on = 1'b0;
    end
  endtask

  task automatic test_clamp();
    run_burst("clamp_zero", 0, ramp(10'h300, DEP), 1'b0);
    run_burst("clamp_1500", 1500, ramp(10'h3F0, DEP), 1'b0);
  endtask

  task automatic test_ignored_trig();
    run_burst("ignored_trig", 5, rand_samples(5), 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    int t, n;
    got.delete();
    start_burst(6, rand_samples(6), 1'b0);
    t = 0;
    while (got.size() < 5 && t < 500) begin @(posedge clk); t++; end
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: wr_en=%0b busy=%0b done=%0b required 0 0 0",
               wr_en, busy, done);
    end
    n = got.size();
    repeat (20) @(posedge clk);
    checks++;
    if (got.size() != 5 || n != 5) begin
      errors++;
      $display("FAIL mid_reset_bytes: got %0d bytes required 5 with none after reset", got.size());
    end
    run_burst("after_reset", 7, rand_samples(7), 1'b0);
  endtask

  task automatic test_single();
    samp_q_t s;
    s.push_back(10'h155);
    run_burst("single", 1, s, 1'b0);
    checks++;
    if (done_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL single_done_timing: done at cycle %0d required %0d", done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(1, 8);
      run_burst("back_to_back", len, rand_samples(len), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_ignored_trig();
    test_reset_mid_drain();
    test_single();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
